// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave backed by a 32-bit word SRAM, serving one burst at a time
module axi_sram_slave #(
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD      = 2'd1;
  localparam logic [1:0] WR_DATA = 2'd2;
  localparam logic [1:0] WR_RESP = 2'd3;
  logic [1:0]  state;
  logic        last_grant;
  logic [3:0]  id;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [7:0]  count;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic        err;
  logic        wl_err;
  logic [31:0] mem [0:DEPTH-1];
  logic        live;
  logic        grant_rd;
  logic        grant_wr;
  logic        ar_hs;
  logic        aw_hs;
  logic        r_hs;
  logic        w_hs;
  logic        b_hs;
  logic        beat_last;
  logic [3:0]  ld_id;
  logic [31:0] ld_addr;
  logic [7:0]  ld_len;
  logic [2:0]  ld_size;
  logic [1:0]  ld_burst;
  logic        ld_err;
  logic [31:0] incr;
  logic [31:0] wrap_mask;
  logic [31:0] next_addr;
  logic [ADDR_W-1:0] widx;
  logic        unused;
  assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};
  // last_grant is 1 once a read was served last; the reset value 0 lets read win the first contention
  assign live      = !areset;
  assign grant_rd  = arvalid && (!awvalid || !last_grant);
  assign grant_wr  = awvalid && !grant_rd;
  assign arready   = live && state == IDLE && grant_rd;
  assign awready   = live && state == IDLE && grant_wr;
  assign rvalid    = live && state == RD;
  assign wready    = live && state == WR_DATA;
  assign bvalid    = live && state == WR_RESP;
  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign r_hs      = rvalid && rready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign beat_last = count == len;
  assign widx      = addr[ADDR_W+1:2];
  assign rid       = id;
  assign bid       = id;
  assign rlast     = rvalid && beat_last;
  assign rdata     = err ? 32'd0 : mem[widx];
  assign rresp     = err ? 2'd2 : 2'd0;
  assign bresp     = (err || wl_err) ? 2'd2 : 2'd0;
  // Payload of whichever address channel is being accepted, plus its legality check
  always_comb begin
    ld_id    = ar_hs ? arid : awid;
    ld_addr  = ar_hs ? araddr : awaddr;
    ld_len   = ar_hs ? arlen : awlen;
    ld_size  = ar_hs ? arsize : awsize;
    ld_burst = ar_hs ? arburst : awburst;
    ld_err   = ld_size > 3'd2 || ld_burst == 2'd3 ||
               (ld_burst == 2'd2 && !(ld_len == 8'd1 || ld_len == 8'd3 || ld_len == 8'd7 || ld_len == 8'd15));
  end
  // Per-beat address step: FIXED holds, WRAP keeps the bits above the burst window, else INCR
  always_comb begin
    incr      = 32'd1 << size;
    wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
    next_addr = burst == 2'd0 ? addr :
                burst == 2'd2 ? (addr & ~wrap_mask) | ((addr + incr) & wrap_mask) : addr + incr;
  end
  // Transaction FSM: accept one address, run its beats, return the write response
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      count      <= 8'd0;
      err        <= 1'b0;
      wl_err     <= 1'b0;
    end else if (ar_hs || aw_hs) begin
      id         <= ld_id;
      addr       <= ld_addr;
      len        <= ld_len;
      size       <= ld_size;
      burst      <= ld_burst;
      err        <= ld_err;
      wl_err     <= 1'b0;
      count      <= 8'd0;
      last_grant <= ar_hs;
      state      <= ar_hs ? RD : WR_DATA;
    end else if (r_hs || w_hs) begin
      addr  <= next_addr;
      count <= count + 8'd1;
      if (w_hs && wlast != beat_last)
        wl_err <= 1'b1;
      if (beat_last)
        state <= r_hs ? IDLE : WR_RESP;
    end else if (b_hs) begin
      state <= IDLE;
    end
  end
  // SRAM: optional clear on reset, byte-lane writes for legal write bursts
  always_ff @(posedge aclk) begin
    if (areset) begin
      if (INIT_ZERO)
        for (int i = 0; i < DEPTH; i++)
          mem[i] <= 32'd0;
    end else if (w_hs && !err) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b])
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed and random AXI bursts checked against a word-array memory model
module tb_axi_sram_slave;
  logic        aclk, areset;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl [0:4095];
  logic [3:0]  r_id, w_id;
  logic [31:0] r_a, w_a;
  logic [7:0]  r_len, w_len;
  logic [2:0]  r_sz, w_sz;
  logic [1:0]  r_bu, w_bu;
  logic [1:0]  bexp;

  axi_sram_slave dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic berr(input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    return sz > 3'd2 || bu == 2'd3 || (bu == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [7:0] len,
                                        input logic [2:0] sz, input logic [1:0] bu, input int i);
    logic [31:0] step, win, base;
    step = 32'd1 << sz;
    win  = (32'(len) + 32'd1) * step;
    if (bu == 2'd0) return a;
    if (bu == 2'd2) begin
      base = a - (a % win);
      return base + ((a - base + 32'(i) * step) % win);
    end
    return a + 32'(i) * step;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4096; i++) mdl[i] = 32'd0;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
    int n;
    r_id = id; r_a = a; r_len = len; r_sz = sz; r_bu = bu;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 40) begin @(posedge aclk); #1; n++; end
    chk("arready", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic r_beats(input int stall_at);
    logic [31:0] a, e;
    logic er;
    int n;
    er = berr(r_len, r_sz, r_bu);
    for (int i = 0; i <= int'(r_len); i++) begin
      a = baddr(r_a, r_len, r_sz, r_bu, i);
      e = er ? 32'd0 : mdl[widx(a)];
      if (i == stall_at) begin
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge aclk); #1;
          chk("stall_rvalid", rvalid, 1);
          chk("stall_rdata", rdata, e);
        end
      end
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < 40) begin @(posedge aclk); #1; n++; end
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, e);
      chk("rid", rid, r_id);
      chk("rresp", rresp, er ? 2 : 0);
      chk("rlast", rlast, i == int'(r_len));
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    chk("rvalid_done", rvalid, 0);
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
    int n;
    w_id = id; w_a = a; w_len = len; w_sz = sz; w_bu = bu;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 40) begin @(posedge aclk); #1; n++; end
    chk("awready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  // wl_mode: 0 wlast on final beat, 1 wlast only on beat 0, 2 wlast never
  task automatic w_beats(input logic [31:0] d0, input bit rnd, input logic [3:0] st, input int wl_mode);
    logic [31:0] a, d;
    logic [3:0] s;
    logic er, lst, bad;
    int n;
    er = berr(w_len, w_sz, w_bu);
    bad = 1'b0;
    for (int i = 0; i <= int'(w_len); i++) begin
      a = baddr(w_a, w_len, w_sz, w_bu, i);
      d = rnd ? $urandom : d0 + 32'(i);
      s = rnd ? 4'($urandom_range(0, 15)) : st;
      lst = wl_mode == 0 ? (i == int'(w_len)) : wl_mode == 1 ? (i == 0) : 1'b0;
      if (lst != (i == int'(w_len))) bad = 1'b1;
      wdata = d; wstrb = s; wlast = lst; wid = 4'($urandom); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 40) begin @(posedge aclk); #1; n++; end
      chk("wready", wready, 1);
      @(posedge aclk); #1;
      if (!er)
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    chk("wready_done", wready, 0);
    bexp = (er || bad) ? 2'd2 : 2'd0;
  endtask

  task automatic b_chk();
    int n;
    bready = 1'b1;
    #1;
    n = 0;
    while (!bvalid && n < 40) begin @(posedge aclk); #1; n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, w_id);
    chk("bresp", bresp, bexp);
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("bvalid_done", bvalid, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0] ln;
    logic [2:0] sz;
    logic [1:0] bu;
    clear_model();
    areset = 1'b1;
    arlock = 2'd0; arcache = 4'd0; arprot = 3'd0;
    awlock = 2'd1; awcache = 4'hF; awprot = 3'd7;
    arid = 4'd1; araddr = 32'h0; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h0; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    areset = 1'b0;
    #1;
    chk("dual0_arready", arready, 1);
    chk("dual0_awready", awready, 0);
    ar_req(4'd1, 32'h0, 8'd0, 3'd2, 2'd1);
    r_beats(-1);
    aw_req(4'd2, 32'h0, 8'd0, 3'd2, 2'd1);
    w_beats(32'hAABBCCDD, 1'b0, 4'b0101, 0);
    b_chk();
    ar_req(4'd3, 32'h0, 8'd0, 3'd2, 2'd1);
    r_beats(-1);
    chk("strobe_word", mdl[0], 32'h00BB00DD);
    arid = 4'd4; araddr = 32'h0; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
    awid = 4'd5; awaddr = 32'h10; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1;
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    chk("dual1_awready", awready, 1);
    chk("dual1_arready", arready, 0);
    aw_req(4'd5, 32'h10, 8'd3, 3'd2, 2'd1);
    w_beats(32'd1, 1'b0, 4'hF, 0);
    b_chk();
    ar_req(4'd4, 32'h0, 8'd0, 3'd2, 2'd1);
    r_beats(-1);
    ar_req(4'd6, 32'h10, 8'd3, 3'd2, 2'd1);
    r_beats(-1);
    ar_req(4'd7, 32'h18, 8'd3, 3'd2, 2'd2);
    r_beats(-1);
    ar_req(4'd8, 32'h10, 8'd3, 3'd2, 2'd1);
    r_beats(1);
    ar_req(4'd9, 32'h10, 8'd3, 3'd3, 2'd1);
    r_beats(-1);
    aw_req(4'hA, 32'h40, 8'd1, 3'd2, 2'd1);
    w_beats(32'h55AA0000, 1'b0, 4'hF, 1);
    b_chk();
    ar_req(4'hA, 32'h40, 8'd1, 3'd2, 2'd1);
    r_beats(-1);
    aw_req(4'hB, 32'h80, 8'd2, 3'd2, 2'd1);
    w_beats(32'h12340000, 1'b0, 4'hF, 2);
    b_chk();
    aw_req(4'hC, 32'h10, 8'd1, 3'd2, 2'd3);
    w_beats(32'hDEAD0000, 1'b0, 4'hF, 0);
    b_chk();
    ar_req(4'hC, 32'h10, 8'd3, 3'd2, 2'd1);
    r_beats(-1);
    for (int t = 0; t < 24; t++) begin
      bu = 2'($urandom_range(0, 2));
      sz = 3'($urandom_range(0, 2));
      ln = bu == 2'd2 ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      a  = $urandom_range(0, 32'hFFFF);
      if ($urandom_range(0, 7) == 0) a = a | 32'hABC0_0000;
      if ($urandom_range(0, 7) == 0) sz = 3'd3;
      aw_req(4'(t), a, ln, sz, bu);
      w_beats(32'd0, 1'b1, 4'd0, 0);
      b_chk();
      ar_req(4'(t + 1), a, ln, sz == 3'd3 ? 3'd2 : sz, bu);
      r_beats(t % 5 == 0 ? 0 : -1);
    end
    ar_req(4'hD, 32'h10, 8'd7, 3'd2, 2'd1);
    rready = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    rready = 1'b0;
    #1;
    chk("rstmid_rvalid", rvalid, 0);
    chk("rstmid_bvalid", bvalid, 0);
    clear_model();
    ar_req(4'hE, 32'h10, 8'd3, 3'd2, 2'd1);
    r_beats(-1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width; memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1, clears memory at reset when 1; otherwise contents are preserved across reset.
REQ-003 aclk  in  1  sole clock; all logic is rising-edge.
REQ-004 areset  in  1  reset, synchronous and active-high.
REQ-005 arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read-address payload.
REQ-006 arlock/arcache/arprot  in  2/4/3  ignored.
REQ-007 arvalid in 1, arready out 1  read-address handshake.
REQ-008 rid/rdata/rresp/rlast  out  4/32/2/1  read-data payload.
REQ-009 rvalid out 1, rready in 1  read-data handshake.
REQ-010 awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write-address payload.
REQ-011 awlock/awcache/awprot  in  2/4/3  ignored.
REQ-012 awvalid in 1, awready out 1  write-address handshake.
REQ-013 wid/wdata/wstrb/wlast  in  4/32/4/1  write data; wid ignored.
REQ-014 wvalid in 1, wready out 1  write-data handshake.
REQ-015 bid/bresp  out  4/2  write response; bvalid out 1, bready in 1.

Function
REQ-016 FSM states: IDLE, RD, WR_DATA, WR_RESP; one transaction in flight at a time.
REQ-017 IDLE: arready/awready = 1 only for the granted channel; grant is combinational on valids.
REQ-018 Both valids in IDLE: grant alternates; a 1-bit last_grant flag (reset = read) picks the channel not served last.
REQ-019 AR handshake latches arid, address, arlen, arsize, arburst and beat counter = 0, then goes to RD.
REQ-020 RD: rvalid = 1; rdata = mem[addr[ADDR_W+1:2]], read combinationally; rid = latched id; rlast = (count == len).
REQ-021 RD beat completes on rvalid&&rready; payload is held stable while rready = 0; after the last beat, next state is IDLE.
REQ-022 AW handshake latches the same fields, then goes to WR_DATA; wready = 1 only in WR_DATA.
REQ-023 Each W beat writes every byte lane i with wstrb[i] = 1 at the current word address; lanes with strobe 0 are unchanged.
REQ-024 WR_DATA exits to WR_RESP on the beat where count == len, regardless of wlast.
REQ-025 WR_RESP: bvalid = 1, bid = latched id; holds until bready, then goes to IDLE.
REQ-026 Address update per beat: FIXED (0) holds; INCR (1) adds 1<<size.
REQ-027 WRAP (2): adds 1<<size, with the low bits wrapping inside a (len+1)<<size aligned window.
REQ-028 Address arithmetic is 32-bit modulo; upper address bits above ADDR_W+1 alias.
REQ-029 Error = size > 2, burst == 3, or WRAP with len not in {1,3,7,15}; error bursts still run all len+1 beats.
REQ-030 Error bursts return rdata = 0 and perform no memory writes.
REQ-031 Response codes: rresp/bresp = OKAY (0); SLVERR (2) on error bursts.
REQ-032 bresp = SLVERR also when wlast mismatches (wlast = 1 before the final beat, or 0 on the final beat); beats are still written.
REQ-033 Outputs are 0 outside their active states: rvalid, rlast, bvalid, wready; rdata/rid/bid are don't-care.

Reset
REQ-034 areset sampled high forces IDLE next cycle, last_grant = read, counters = 0, and all ready/valid outputs = 0.
REQ-035 Reset mid-burst abandons the burst; no further beats or responses are produced.
REQ-036 INIT_ZERO = 1: every memory word reads 0 after reset.
REQ-037 No handshake is accepted in a cycle where areset = 1.

Verification
REQ-038 Write INCR awaddr 0x10, len 3, size 2, data 1..4, wstrb F -> bresp 0; then read the same burst -> rdata 1,2,3,4 with rlast on beat 4.
REQ-039 WRAP read araddr 0x18, len 3, size 2 -> word addresses 0x18,0x1C,0x10,0x14.
REQ-040 Write 0xAABBCCDD to 0x0 with wstrb 0101, after 0 init -> read returns 0x00BB00DD.
REQ-041 awvalid and arvalid both high from reset -> read served first, then write; repeated dual requests alternate.
REQ-042 rready held low 5 cycles mid-burst -> rvalid stays 1 and rdata stable; then arsize = 3 -> rresp 2 on all beats.
REQ-043 Write len 1 with wlast = 1 on beat 0 -> bresp 2 and both beats written; areset mid-read -> rvalid = 0 next cycle.
